// File: rtl/demux_1to16_hs_if.sv
// Handshake and data bundle for demux_1to16_hs: the input word side and the 16-lane delivery side.
// WIDTH must match the WIDTH of the demux instance it connects to.
interface demux_1to16_hs_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [3:0]       sel;
    logic             seq_mode;
    logic [WIDTH-1:0] out_data;
    logic [15:0]      out_valid;
    logic [15:0]      out_ready;
    logic [3:0]       lane_cnt;
    logic             timeout_err;

    // valid/ready: a transfer happens on a rising edge where valid and ready are both high;
    // once valid rises, it and its payload hold until that edge, and ready may depend on nothing the source drives.
    modport master (
        output in_valid, in_data, sel, seq_mode, out_ready,
        input  in_ready, out_data, out_valid, lane_cnt, timeout_err
    );

    modport slave (
        input  in_valid, in_data, sel, seq_mode, out_ready,
        output in_ready, out_data, out_valid, lane_cnt, timeout_err
    );
endinterface

// File: rtl/demux_1to16_hs.sv
// 1-to-16 registered demultiplexer with valid/ready handshake; lane from sel or a wrapping lane counter.
// Optional DEMUX_TIMEOUT_EN aborts a delivery that waits TIMEOUT cycles in SEND and pulses timeout_err.
module demux_1to16_hs #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    demux_1to16_hs_if.slave bus,
    output logic            dbg_state
);
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [3:0]       lane_q, lane_d;
    logic             seq_q, seq_d;
    logic [3:0]       lane_cnt_q, lane_cnt_d;
    logic             accept;
    logic             done;

`ifdef DEMUX_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
    logic [7:0] wait_q, wait_d;
    logic       terr_q, terr_d;
    logic       expire;
`endif

    assign accept = (state_q == IDLE) && bus.in_valid;
    // Only the latched lane's ready bit can finish a delivery.
    assign done   = (state_q == SEND) && bus.out_ready[lane_q];

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        lane_d     = lane_q;
        seq_d      = seq_q;
        lane_cnt_d = lane_cnt_q;
`ifdef DEMUX_TIMEOUT_EN
        wait_d     = wait_q;
        terr_d     = 1'b0;
        expire     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d  = bus.in_data;
                    lane_d  = bus.seq_mode ? lane_cnt_q : bus.sel;
                    seq_d   = bus.seq_mode;
                    state_d = SEND;
`ifdef DEMUX_TIMEOUT_EN
                    wait_d  = 8'd0;
`endif
                end
            end
            SEND: begin
`ifdef DEMUX_TIMEOUT_EN
                expire = (wait_q == WAIT_LAST);
                wait_d = wait_q + 8'd1;
`endif
                // Completion wins over a timeout firing in the same cycle.
                if (done) begin
                    state_d = IDLE;
                    if (seq_q) begin
                        lane_cnt_d = lane_cnt_q + 4'd1;
                    end
                end
`ifdef DEMUX_TIMEOUT_EN
                else if (expire) begin
                    state_d = IDLE;
                    terr_d  = 1'b1;
                    // A dead sequential lane is skipped rather than retried.
                    if (seq_q) begin
                        lane_cnt_d = lane_cnt_q + 4'd1;
                    end
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            data_q     <= '0;
            lane_q     <= 4'd0;
            seq_q      <= 1'b0;
            lane_cnt_q <= 4'd0;
`ifdef DEMUX_TIMEOUT_EN
            wait_q     <= 8'd0;
            terr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            lane_q     <= lane_d;
            seq_q      <= seq_d;
            lane_cnt_q <= lane_cnt_d;
`ifdef DEMUX_TIMEOUT_EN
            wait_q     <= wait_d;
            terr_q     <= terr_d;
`endif
        end
    end

    // out_valid decodes straight from the state flop so an async reset drops it at once.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == SEND) ? (16'h0001 << lane_q) : 16'h0000;
    assign bus.out_data  = data_q;
    assign bus.lane_cnt  = lane_cnt_q;
    assign dbg_state     = state_q;

`ifdef DEMUX_TIMEOUT_EN
    assign bus.timeout_err = terr_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    a_out_valid_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(bus.out_valid));

    a_ready_iff_idle: assert property (@(posedge clk) disable iff (!rst_n)
        bus.in_ready == (bus.out_valid == 16'h0000));

    a_data_stable_in_send: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == SEND && state_d == SEND) |=> $stable(bus.out_data));

    a_timeout_range: assert property (@(posedge clk)
        (TIMEOUT >= 1) && (TIMEOUT <= 255));
endmodule

// File: tb/tb_demux_1to16_hs.sv
// Self-checking bench for demux_1to16_hs: directed scenarios plus random traffic against a lane/counter model.
// Build with DEMUX_TIMEOUT_EN defined to exercise the abort path (TIMEOUT=4).
`timescale 1ns/1ps
module tb_demux_1to16_hs;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 4;
`ifdef DEMUX_TIMEOUT_EN
    localparam int T3_HOLD = 3;
`else
    localparam int T3_HOLD = 5;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic dbg_state;

    demux_1to16_hs_if #(.WIDTH(WIDTH)) bus ();

    demux_1to16_hs #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int model_cnt = 0;
    logic [11:0] exp_q[$];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.sel       = 4'd0;
        bus.seq_mode  = 1'b0;
        bus.out_ready = 16'h0000;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        model_cnt = 0;
        exp_q.delete();
        tick();
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_in_ready: got in_ready=%b after %0d cycles, expected 1", bus.in_ready, n);
        end
    endtask

    // One word end to end; hold = extra SEND cycles with the target lane not ready.
    task automatic deliver(input logic [7:0] d, input logic [3:0] s, input logic seq,
                           input int hold, input logic [15:0] other);
        logic [3:0]  lane;
        logic [15:0] onehot;
        logic [11:0] exp;
        wait_ready();
        lane   = seq ? model_cnt[3:0] : s;
        onehot = 16'h0001 << lane;
        exp_q.push_back({lane, d});
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.sel       = s;
        bus.seq_mode  = seq;
        bus.out_ready = (hold == 0) ? 16'hFFFF : (other & ~onehot);
        tick();
        exp = exp_q.pop_front();
        bus.in_data  = ~d;
        bus.sel      = ~s;
        bus.seq_mode = ~seq;
        n_checks++;
        if (bus.out_valid !== (16'h0001 << exp[11:8])) begin
            n_fail++;
            $display("FAIL accept_out_valid: got %h expected %h", bus.out_valid, 16'h0001 << exp[11:8]);
        end
        n_checks++;
        if (bus.out_data !== exp[7:0]) begin
            n_fail++;
            $display("FAIL accept_out_data: got %h expected %h", bus.out_data, exp[7:0]);
        end
        n_checks++;
        if (bus.in_ready !== 1'b0 || dbg_state !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_busy: got in_ready=%b state=%b expected 0/1", bus.in_ready, dbg_state);
        end
        for (int i = 1; i <= hold; i++) begin
            tick();
            n_checks++;
            if (bus.out_valid !== onehot || bus.out_data !== d || bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: got valid=%h data=%h in_ready=%b expected %h/%h/0",
                         i, bus.out_valid, bus.out_data, bus.in_ready, onehot, d);
            end
            n_checks++;
            if (bus.timeout_err !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_timeout_err: got %b expected 0", bus.timeout_err);
            end
            if (i == hold) bus.out_ready = onehot;
        end
        tick();
        bus.in_valid = 1'b0;
        if (seq) model_cnt = (model_cnt + 1) % 16;
        n_checks++;
        if (bus.out_valid !== 16'h0000 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL complete: got valid=%h in_ready=%b expected 0000/1", bus.out_valid, bus.in_ready);
        end
        n_checks++;
        if (bus.out_data !== d || bus.lane_cnt !== model_cnt[3:0]) begin
            n_fail++;
            $display("FAIL complete_hold: got data=%h lane_cnt=%0d expected %h/%0d",
                     bus.out_data, bus.lane_cnt, d, model_cnt);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (bus.out_valid !== 16'h0 || bus.out_data !== 8'h00 || bus.lane_cnt !== 4'd0 ||
            bus.timeout_err !== 1'b0 || bus.in_ready !== 1'b1 || dbg_state !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got valid=%h data=%h cnt=%0d terr=%b rdy=%b st=%b expected 0/0/0/0/1/0",
                     bus.out_valid, bus.out_data, bus.lane_cnt, bus.timeout_err, bus.in_ready, dbg_state);
        end
        deliver(8'h5A, 4'd7, 1'b1, 0, 16'h0);
        wait_ready();
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'hC3;
        bus.sel       = 4'd4;
        bus.seq_mode  = 1'b0;
        bus.out_ready = 16'h0000;
        tick();
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 16'h0010) begin
            n_fail++;
            $display("FAIL reset_presend: got %h expected 0010", bus.out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 16'h0 || bus.lane_cnt !== 4'd0 || bus.in_ready !== 1'b1 || bus.out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_async: got valid=%h cnt=%0d rdy=%b data=%h expected 0000/0/1/00",
                     bus.out_valid, bus.lane_cnt, bus.in_ready, bus.out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_cnt = 0;
        exp_q.delete();
        tick();
    endtask

    task automatic test_direct();
        deliver(8'hA7, 4'd5, 1'b0, 0, 16'hFFFF);
        deliver(8'h00, 4'd15, 1'b0, 0, 16'hFFFF);
        deliver(8'hFF, 4'd0, 1'b0, 1, 16'hFFFF);
    endtask

    task automatic test_backpressure();
        deliver(8'h3C, 4'd3, 1'b0, T3_HOLD, 16'hFFF7);
    endtask

    task automatic test_seq_wrap();
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            deliver(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), 1'b1, 0, 16'hFFFF);
        end
        n_checks++;
        if (bus.lane_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL seq_wrap_cnt: got %0d expected 1", bus.lane_cnt);
        end
    endtask

    task automatic test_mode_mix();
        apply_reset();
        deliver(8'h11, 4'd12, 1'b1, 0, 16'hFFFF);
        deliver(8'h22, 4'd9, 1'b0, 0, 16'hFFFF);
        deliver(8'h33, 4'd6, 1'b1, 0, 16'hFFFF);
        n_checks++;
        if (bus.lane_cnt !== 4'd2) begin
            n_fail++;
            $display("FAIL mode_mix_cnt: got %0d expected 2", bus.lane_cnt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            deliver(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), 16'($urandom_range(0, 65535)));
        end
    endtask

`ifdef DEMUX_TIMEOUT_EN
    task automatic test_timeout();
        logic [15:0] onehot;
        apply_reset();
        for (int run = 0; run < 2; run++) begin
            wait_ready();
            onehot = 16'h0001 << model_cnt[3:0];
            bus.in_valid  = 1'b1;
            bus.in_data   = 8'h9E;
            bus.sel       = 4'd11;
            bus.seq_mode  = 1'b1;
            bus.out_ready = 16'h0000;
            tick();
            bus.in_valid = 1'b0;
            for (int c = 1; c <= TIMEOUT; c++) begin
                n_checks++;
                if (bus.out_valid !== onehot || bus.timeout_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL to_send_c%0d: got valid=%h terr=%b expected %h/0",
                             c, bus.out_valid, bus.timeout_err, onehot);
                end
                if (run == 1 && c == TIMEOUT) bus.out_ready = onehot;
                tick();
            end
            model_cnt = (model_cnt + 1) % 16;
            n_checks++;
            if (bus.out_valid !== 16'h0 || bus.timeout_err !== ((run == 0) ? 1'b1 : 1'b0) ||
                bus.lane_cnt !== model_cnt[3:0]) begin
                n_fail++;
                $display("FAIL to_end_run%0d: got valid=%h terr=%b cnt=%0d expected 0000/%0d/%0d",
                         run, bus.out_valid, bus.timeout_err, bus.lane_cnt, (run == 0) ? 1 : 0, model_cnt);
            end
            bus.out_ready = 16'h0000;
            tick();
            n_checks++;
            if (bus.timeout_err !== 1'b0) begin
                n_fail++;
                $display("FAIL to_pulse_width: got %b expected 0", bus.timeout_err);
            end
        end
    endtask
`else
    task automatic test_no_timeout();
        deliver(8'h6B, 4'd14, 1'b1, 30, 16'h0000);
    endtask
`endif

    initial begin
        idle_inputs();
        test_reset();
        test_direct();
        test_backpressure();
        test_seq_wrap();
        test_mode_mix();
        test_random();
`ifdef DEMUX_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
